// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and defaults for the fetch->decode instruction queue.
package fetch_inst_queue_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_INST_WIDTH = 32;

  // One buffered instruction as it travels from fetch to decode.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] pc;
    logic [DEF_INST_WIDTH-1:0] inst;
  } inst_entry_t;

  localparam inst_entry_t ZERO_ENTRY = '0;

endpackage

// File: rtl/fetch_inst_queue_if.sv
// Fetch/decode bundle of the instruction queue.
// Optional perf counter signals exist only when INST_QUEUE_PERF_EN is defined.
//
// Handshake: a fetch group is taken on a clock edge where fetch_ready_o is high
// and at least one fetch_valid_i bit is set; fetch_ready_o depends only on the
// registered occupancy, so fetch must hold its group while it is low. Decode
// sees decode_valid_o as a prefix of slots; with decode_ready_i high it takes
// every valid slot on that edge.
interface fetch_inst_queue_if #(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = fetch_inst_queue_pkg::DEF_ADDR_WIDTH,
  parameter int INST_WIDTH   = fetch_inst_queue_pkg::DEF_INST_WIDTH
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                               flush;
  logic [FETCH_WIDTH-1:0]             fetch_valid_i;
  logic [FETCH_WIDTH*ADDR_WIDTH-1:0]  fetch_pc_i;
  logic [FETCH_WIDTH*INST_WIDTH-1:0]  fetch_inst_i;
  logic                               fetch_ready_o;
  logic [DECODE_WIDTH-1:0]            decode_valid_o;
  logic [DECODE_WIDTH*ADDR_WIDTH-1:0] decode_pc_o;
  logic [DECODE_WIDTH*INST_WIDTH-1:0] decode_inst_o;
  logic                               decode_ready_i;
  logic [CNT_W-1:0]                   count_o;
`ifdef INST_QUEUE_PERF_EN
  logic [31:0]                        perf_full_cycles_o;
  logic [31:0]                        perf_empty_cycles_o;
`endif

  modport slave (
    input  flush, fetch_valid_i, fetch_pc_i, fetch_inst_i, decode_ready_i,
`ifdef INST_QUEUE_PERF_EN
    output perf_full_cycles_o, perf_empty_cycles_o,
`endif
    output fetch_ready_o, decode_valid_o, decode_pc_o, decode_inst_o, count_o
  );

  modport master (
    output flush, fetch_valid_i, fetch_pc_i, fetch_inst_i, decode_ready_i,
`ifdef INST_QUEUE_PERF_EN
    input  perf_full_cycles_o, perf_empty_cycles_o,
`endif
    input  fetch_ready_o, decode_valid_o, decode_pc_o, decode_inst_o, count_o
  );

endinterface

// File: rtl/fetch_inst_queue_compact.sv
// inst_slot_compact: maps per-slot valid bits to compacted write offsets
// (exclusive prefix popcount) and the total number of valid slots.
module inst_slot_compact #(
  parameter int WIDTH = 2,
  parameter int OW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]    valid_i,
  output logic [WIDTH*OW-1:0] offset_o,
  output logic [OW-1:0]       count_o
);

  logic [OW-1:0] run;

  // Running popcount: each slot's offset is the number of valid slots below it.
  always_comb begin
    offset_o = '0;
    run      = '0;
    for (int k = 0; k < WIDTH; k++) begin
      offset_o[k*OW +: OW] = run;
      run                  = run + OW'(valid_i[k]);
    end
    count_o = run;
  end

endmodule

// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: DEPTH-entry circular buffer between fetch and decode.
// Optional feature macro: INST_QUEUE_PERF_EN (full/empty cycle counters).
module fetch_inst_queue
  import fetch_inst_queue_pkg::*;
#(
  parameter int FETCH_WIDTH  = 2,
  parameter int DECODE_WIDTH = 2,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int INST_WIDTH   = DEF_INST_WIDTH
) (
  input logic              clk,
  input logic              rst,
  fetch_inst_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(FETCH_WIDTH + 1);

  logic [ADDR_WIDTH-1:0]       mem_pc   [DEPTH];
  logic [INST_WIDTH-1:0]       mem_inst [DEPTH];
  logic [PW-1:0]               head_q, tail_q;
  logic [CW-1:0]               count_q;
  logic [FETCH_WIDTH*OW-1:0]   offs;
  logic [OW-1:0]               enq_n;
  logic                        fetch_ready, enq_fire;
  logic [CW-1:0]               enq_cnt, deq_cnt;
  logic [DECODE_WIDTH-1:0]            dec_valid;
  logic [DECODE_WIDTH*ADDR_WIDTH-1:0] dec_pc;
  logic [DECODE_WIDTH*INST_WIDTH-1:0] dec_inst;

  inst_slot_compact #(.WIDTH(FETCH_WIDTH), .OW(OW)) u_compact (
    .valid_i  (bus.fetch_valid_i),
    .offset_o (offs),
    .count_o  (enq_n)
  );

  // Registered-count-only ready keeps decode_ready_i off the fetch path.
  assign fetch_ready = (count_q <= CW'(DEPTH - FETCH_WIDTH));
  assign enq_fire    = fetch_ready && (|bus.fetch_valid_i);

  // Per-cycle enqueue and dequeue amounts.
  always_comb begin
    enq_cnt = enq_fire ? CW'(enq_n) : '0;
    deq_cnt = '0;
    if (bus.decode_ready_i) begin
      deq_cnt = (count_q < CW'(DECODE_WIDTH)) ? count_q : CW'(DECODE_WIDTH);
    end
  end

  // Pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PW'(deq_cnt);
      tail_q  <= tail_q + PW'(enq_cnt);
      count_q <= count_q + enq_cnt - deq_cnt;
    end
  end

  // Compacted writes of the valid fetch slots starting at tail (wraps naturally).
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && enq_fire) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (bus.fetch_valid_i[k]) begin
          mem_pc[tail_q + PW'(offs[k*OW +: OW])]   <= bus.fetch_pc_i[k*ADDR_WIDTH +: ADDR_WIDTH];
          mem_inst[tail_q + PW'(offs[k*OW +: OW])] <= bus.fetch_inst_i[k*INST_WIDTH +: INST_WIDTH];
        end
      end
    end
  end

  // Decode view: prefix-valid slots from head, data masked to zero when invalid.
  always_comb begin
    dec_valid = '0;
    dec_pc    = '0;
    dec_inst  = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      if (count_q > CW'(k)) begin
        dec_valid[k]                        = 1'b1;
        dec_pc[k*ADDR_WIDTH +: ADDR_WIDTH]  = mem_pc[head_q + PW'(k)];
        dec_inst[k*INST_WIDTH +: INST_WIDTH] = mem_inst[head_q + PW'(k)];
      end
    end
  end

  assign bus.fetch_ready_o  = fetch_ready;
  assign bus.decode_valid_o = dec_valid;
  assign bus.decode_pc_o    = dec_pc;
  assign bus.decode_inst_o  = dec_inst;
  assign bus.count_o        = count_q;

`ifdef INST_QUEUE_PERF_EN
  logic [31:0] perf_full_q, perf_empty_q;

  // Saturating stall/starve counters; only reset clears them, flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_full_q  <= '0;
      perf_empty_q <= '0;
    end else begin
      if (!fetch_ready && (perf_full_q != '1)) perf_full_q <= perf_full_q + 32'd1;
      if ((count_q == '0) && (perf_empty_q != '1)) perf_empty_q <= perf_empty_q + 32'd1;
    end
  end

  assign bus.perf_full_cycles_o  = perf_full_q;
  assign bus.perf_empty_cycles_o = perf_empty_q;
`endif

endmodule
